// File: rtl/button_conditioner_if.sv
// Button conditioner port bundle: raw button inputs and the conditioned
// level/event outputs for N_CH channels.
interface button_conditioner_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_raw_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] rpt_o;

  // Drives the buttons and observes the conditioned outputs.
  modport master (
    output btn_raw_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  rpt_o
  );

  // The conditioner itself.
  modport slave (
    input  btn_raw_i,
    output level_o,
    output press_o,
    output release_o,
    output rpt_o
  );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner. Each channel synchronises its raw
// input, debounces it into a stable level, emits press/release pulses on level
// changes, and drives an action pulse at press time and (optionally) at
// auto-repeat instants while the button stays held.
module button_conditioner #(
  parameter int              N_CH       = 4,
  parameter int              DB_CYCLES  = 250000,
  parameter int              RPT_DELAY  = 10000000,
  parameter int              RPT_PERIOD = 2500000,
  parameter logic [N_CH-1:0] RPT_MASK   = {N_CH{1'b1}},
  parameter bit              ACTIVE_LOW = 1'b1
) (
  input  logic                clock,
  input  logic                resetn,
  button_conditioner_if.slave bus
);

  // Debounce counter only ever needs to reach DB_CYCLES-1.
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  // One timer per channel serves both the initial delay and the repeat period.
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int TMR_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(RPT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } rpt_state_e;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic             raw_in;
    logic             sync1_q;
    logic             sync2_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [DB_W-1:0]  db_cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             release_q;
    logic             rpt_q;
    logic             accept_press;
    logic             accept_release;
    rpt_state_e       state_q;
    logic [TMR_W-1:0] timer_q;

    // Polarity is normalised before the synchroniser so pressed is always 1.
    assign raw_in = ACTIVE_LOW ? ~bus.btn_raw_i[gi] : bus.btn_raw_i[gi];

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw_in;
        sync2_q <= sync1_q;
      end
    end

    // Debounce next state: count consecutive cycles of disagreement with the
    // accepted level; any agreement restarts the count.
    always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      if (sync2_q == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_cnt_d = '0;
        level_d  = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    assign accept_press   = ~level_q &  level_d;
    assign accept_release =  level_q & ~level_d;

    // Debounced level plus press/release pulses, registered together so the
    // pulse lands in the first cycle the new level is visible.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= accept_press;
        release_q <= accept_release;
      end
    end

    // Auto-repeat FSM; a release always wins over a coincident timer expiry.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        state_q <= S_IDLE;
        timer_q <= '0;
        rpt_q   <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (accept_release) begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (accept_press) begin
                rpt_q   <= 1'b1;
                timer_q <= '0;
                if (RPT_MASK[gi]) begin
                  state_q <= S_DELAY;
                end
              end
            end
            S_DELAY: begin
              if (timer_q == DELAY_LAST) begin
                rpt_q   <= 1'b1;
                timer_q <= '0;
                state_q <= S_REPEAT;
              end else begin
                timer_q <= timer_q + TMR_W'(1);
              end
            end
            S_REPEAT: begin
              if (timer_q == PERIOD_LAST) begin
                rpt_q   <= 1'b1;
                timer_q <= '0;
              end else begin
                timer_q <= timer_q + TMR_W'(1);
              end
            end
            default: begin
              state_q <= S_IDLE;
              timer_q <= '0;
            end
          endcase
        end
      end
    end

    assign bus.level_o[gi]   = level_q;
    assign bus.press_o[gi]   = press_q;
    assign bus.release_o[gi] = release_q;
    assign bus.rpt_o[gi]     = rpt_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with 2 channels, DB_CYCLES=4,
// RPT_DELAY=10, RPT_PERIOD=3, RPT_MASK=2'b01, active-high inputs.
// Cycle c: inputs applied at its start are sampled at its closing edge;
// outputs are read 1 time unit after its opening edge.
module tb_button_conditioner;
  localparam int N_CH = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  logic [1:0] el;
  logic [1:0] ep;
  logic [1:0] er;
  logic [1:0] et;
  logic [7:0] obs;

  button_conditioner_if #(.N_CH(N_CH)) bus ();

  button_conditioner #(
    .N_CH      (N_CH),
    .DB_CYCLES (4),
    .RPT_DELAY (10),
    .RPT_PERIOD(3),
    .RPT_MASK  (2'b01),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign obs = {bus.level_o, bus.press_o, bus.release_o, bus.rpt_o};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic compare(input string tag, input int c, input logic [7:0] exp_v);
    n_cmp++;
    $display("[%s] cycle %0d lvl/prs/rel/rpt=%b expect=%b", tag, c, obs, exp_v);
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp_v);
    end
  endtask

  initial begin
    bus.btn_raw_i = 2'b00;

    // Reset state
    for (int c = 0; c < 3; c++) begin
      tick();
      compare("reset", c, 8'h00);
    end

    // Both channels pressed at cycle 0; ch0 released at 30, ch1 at 40
    resetn = 1'b1;
    for (int c = 0; c < 56; c++) begin
      bus.btn_raw_i[0] = (c < 30);
      bus.btn_raw_i[1] = (c < 40);
      el[0] = (c >= 6) && (c < 36);
      ep[0] = (c == 6);
      er[0] = (c == 36);
      et[0] = (c == 6) || (c == 16) || (c == 19) || (c == 22) || (c == 25) ||
              (c == 28) || (c == 31) || (c == 34);
      el[1] = (c >= 6) && (c < 46);
      ep[1] = (c == 6);
      er[1] = (c == 46);
      et[1] = (c == 6);
      compare("hold_release", c, {el, ep, er, et});
      tick();
    end

    // Ch0 bounces with 3-cycle bursts for 40 cycles: nothing accepted
    for (int c = 0; c < 50; c++) begin
      bus.btn_raw_i[0] = (c < 40) && (((c / 3) % 2) == 0);
      bus.btn_raw_i[1] = 1'b0;
      compare("glitch", c, 8'h00);
      tick();
    end

    // Ch0 held, reset during cycles 12-13, released at 30 so the release
    // coincides with a repeat expiry
    for (int c = 0; c < 46; c++) begin
      resetn = !((c == 12) || (c == 13));
      bus.btn_raw_i[0] = (c < 30);
      bus.btn_raw_i[1] = 1'b0;
      el = 2'b00;
      ep = 2'b00;
      er = 2'b00;
      et = 2'b00;
      el[0] = ((c >= 6) && (c <= 12)) || ((c >= 20) && (c < 36));
      ep[0] = (c == 6) || (c == 20);
      er[0] = (c == 36);
      et[0] = (c == 6) || (c == 20) || (c == 30) || (c == 33);
      compare("reset_held", c, {el, ep, er, et});
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
